// File: rtl/branch_predictor.sv
// Bimodal 2-bit counter table plus tagged BTB, queried by fetch and trained by execute.
// Lookups answer one cycle after the request; a same-edge update is seen only by later lookups.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_req,
  input  logic [31:0] pred_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          ctr_reg    [ENTRIES];
  logic [ENTRIES-1:0]  valid_reg;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [31:0]         target_mem [ENTRIES];

  logic [IDX_BITS-1:0] pred_idx;
  logic [TAG_BITS-1:0] pred_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                lookup_hit;
  logic [1:0]          upd_ctr_next;

  logic        pred_valid_reg;
  logic        pred_taken_reg;
  logic        pred_hit_reg;
  logic [31:0] pred_target_reg;
  logic [31:0] branch_count_reg;
  logic [31:0] mispred_count_reg;

  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign pred_tag = pred_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
  assign upd_tag  = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  assign lookup_hit = valid_reg[pred_idx] && (tag_mem[pred_idx] == pred_tag);

  // Saturating step of the counter selected by the update PC.
  always_comb begin
    upd_ctr_next = ctr_reg[upd_idx];
    if (upd_taken) begin
      if (ctr_reg[upd_idx] != 2'b11) upd_ctr_next = ctr_reg[upd_idx] + 2'd1;
    end else begin
      if (ctr_reg[upd_idx] != 2'b00) upd_ctr_next = ctr_reg[upd_idx] - 2'd1;
    end
  end

  // Counters and valid bits need a full clear on reset, so they live in flops per entry.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ctr_reg[gi]   <= 2'b01;
          valid_reg[gi] <= 1'b0;
        end else if (upd_valid && (upd_idx == IDX_BITS'(gi))) begin
          ctr_reg[gi] <= upd_ctr_next;
          if (upd_taken) valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and target payload is qualified by valid_reg, so it needs no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_reg  <= 1'b0;
      pred_taken_reg  <= 1'b0;
      pred_hit_reg    <= 1'b0;
      pred_target_reg <= 32'd0;
    end else begin
      pred_valid_reg  <= pred_req;
      pred_hit_reg    <= pred_req && lookup_hit;
      pred_taken_reg  <= pred_req && lookup_hit && ctr_reg[pred_idx][1];
      pred_target_reg <= (pred_req && lookup_hit) ? target_mem[pred_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count_reg  <= 32'd0;
      mispred_count_reg <= 32'd0;
    end else if (upd_valid) begin
      branch_count_reg  <= branch_count_reg + 32'd1;
      mispred_count_reg <= mispred_count_reg + {31'd0, upd_mispredict};
    end
  end

  assign pred_valid    = pred_valid_reg;
  assign pred_taken    = pred_taken_reg;
  assign pred_hit      = pred_hit_reg;
  assign pred_target   = pred_target_reg;
  assign branch_count  = branch_count_reg;
  assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and random checks of branch_predictor against a table-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  int checks = 0;
  int fails  = 0;

  // Reference model: 64 entries, counters held as plain integers 0..3.
  int          m_ctr [64];
  bit          m_val [64];
  int          m_tag [64];
  logic [31:0] m_tgt [64];
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_hit(pred_hit), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .branch_count(branch_count), .mispred_count(mispred_count)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / 256) % 256);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 0;
      m_tag[i] = 0;
      m_tgt[i] = 32'd0;
    end
    m_bc = 32'd0;
    m_mc = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, check the response after the rising edge.
  task automatic step(input logic req, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic um);
    int i;
    int j;
    bit e_hit;
    bit e_taken;
    logic [31:0] e_tgt;
    pred_req = req; pred_pc = pc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; upd_mispredict = um;
    i = idx_of(pc);
    e_hit   = req && m_val[i] && (m_tag[i] == tag_of(pc));
    e_taken = e_hit && (m_ctr[i] >= 2);
    e_tgt   = e_hit ? m_tgt[i] : 32'd0;
    @(posedge clk);
    #1;
    if (uv) begin
      j = idx_of(upc);
      if (ut) begin
        m_ctr[j] = (m_ctr[j] == 3) ? 3 : m_ctr[j] + 1;
        m_val[j] = 1;
        m_tag[j] = tag_of(upc);
        m_tgt[j] = utgt;
      end else begin
        m_ctr[j] = (m_ctr[j] == 0) ? 0 : m_ctr[j] - 1;
      end
      m_bc = m_bc + 32'd1;
      m_mc = m_mc + (um ? 32'd1 : 32'd0);
    end
    $display("step req=%0b pc=%h upd=%0b upc=%h t=%0b -> valid=%0b hit=%0b taken=%0b tgt=%h bc=%0d mc=%0d",
             req, pc, uv, upc, ut, pred_valid, pred_hit, pred_taken, pred_target,
             branch_count, mispred_count);
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, req});
    chk("pred_hit",   {31'd0, pred_hit},   {31'd0, e_hit});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_taken});
    chk("pred_target", pred_target, e_tgt);
    chk("branch_count", branch_count, m_bc);
    chk("mispred_count", mispred_count, m_mc);
    @(negedge clk);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    step(1'b0, 32'd0, 1'b1, pc, t, tgt, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    pred_req = 0; pred_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_mispredict = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", {31'd0, pred_valid}, 32'd0);
    chk("reset_hit",   {31'd0, pred_hit},   32'd0);
    chk("reset_target", pred_target, 32'd0);
    chk("reset_bc", branch_count, 32'd0);
    chk("reset_mc", mispred_count, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // T1: cold lookup
    lookup(32'h100);
    // T2: train taken twice
    train(32'h100, 1'b1, 32'h200);
    train(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    chk("t2_target_direct", pred_target, 32'h200);
    // T3: saturation
    for (int k = 0; k < 5; k++) train(32'h40, 1'b1, 32'h44);
    train(32'h40, 1'b0, 32'h0);
    lookup(32'h40);
    chk("t3_taken_after_1nt", {31'd0, pred_taken}, 32'd1);
    train(32'h40, 1'b0, 32'h0);
    lookup(32'h40);
    chk("t3_taken_after_2nt", {31'd0, pred_taken}, 32'd0);
    chk("t3_hit_after_2nt", {31'd0, pred_hit}, 32'd1);
    // T4: alias on same index with new tag
    train(32'h100, 1'b1, 32'h200);
    train(32'h4100, 1'b1, 32'h300);
    lookup(32'h100);
    chk("t4_old_tag_miss", {31'd0, pred_hit}, 32'd0);
    lookup(32'h4100);
    chk("t4_new_target", pred_target, 32'h300);
    // T5: same-edge lookup and update returns pre-update state
    train(32'h80, 1'b1, 32'h500);
    train(32'h80, 1'b0, 32'h0);
    step(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0);
    chk("t5_collision_taken", {31'd0, pred_taken}, 32'd0);
    lookup(32'h80);
    chk("t5_next_taken", {31'd0, pred_taken}, 32'd1);
    // Low PC bits ignored
    lookup(32'h83);
    // Random mix over a small PC set to provoke aliasing and collisions
    for (int k = 0; k < 300; k++) begin
      logic [31:0] lp;
      logic [31:0] up;
      lp = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      up = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      step(1'($urandom_range(0, 1)), lp, 1'($urandom_range(0, 1)), up,
           1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    // Back-to-back lookups
    for (int k = 0; k < 8; k++) lookup(32'(k * 4));
    // T6: statistics wrap
    force dut.branch_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count_reg;
    m_bc = 32'hFFFF_FFFF;
    step(1'b0, 32'd0, 1'b1, 32'h300, 1'b0, 32'd0, 1'b1);
    chk("t6_bc_wrapped", branch_count, 32'd0);
    // Asynchronous reset while a response is due
    pred_req = 1'b1; pred_pc = 32'h4100;
    upd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", {31'd0, pred_valid}, 32'd0);
    chk("async_rst_target", pred_target, 32'd0);
    chk("async_rst_bc", branch_count, 32'd0);
    chk("async_rst_mc", mispred_count, 32'd0);
    @(negedge clk);
    pred_req = 1'b0;
    rst = 1'b1;
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    lookup(32'h4100);
    chk("post_rst_btb_cleared", {31'd0, pred_hit}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
